// File: rtl/button_evt_pkg.sv
// Shared definitions for the front-panel button event decoders: state encoding and
// default tick counts for a 100 Hz tick.
package button_evt_pkg;

    typedef enum logic [1:0] {
        ST_LOCKOUT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_HELD    = 2'd3
    } btn_state_e;

    // One second to long press, five repeats per second once held.
    localparam int unsigned DEFAULT_HOLD_TICKS   = 100;
    localparam int unsigned DEFAULT_REPEAT_TICKS = 20;

    function automatic bit fits_width(input int unsigned val, input int unsigned width);
        return (val != 0) && (64'(val) < (64'd1 << width));
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Tick-enabled up-counter with synchronous clear and a terminal-count compare flag.
module tick_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q;

    // Clear wins over enable, so the owner can compare-and-clear without ever wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign at_term = (cnt_q == term);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long-press/auto-repeat pulses.
// Auto-repeat is built only when AUTO_REPEAT_EN is defined; otherwise repeat_pulse is tied 0.
module button_event_decoder
    import button_evt_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned HOLD_TICKS   = DEFAULT_HOLD_TICKS,
    parameter int unsigned REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_db,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    if (!fits_width(HOLD_TICKS, CNT_W)) begin : g_bad_hold
        $error("HOLD_TICKS must be nonzero and fit in CNT_W bits");
    end
    if (!fits_width(REPEAT_TICKS, CNT_W)) begin : g_bad_repeat
        $error("REPEAT_TICKS must be nonzero and fit in CNT_W bits");
    end

`ifdef AUTO_REPEAT_EN
    localparam bit AutoRepeat = 1'b1;
`else
    localparam bit AutoRepeat = 1'b0;
`endif

    localparam logic [CNT_W-1:0] HoldTerm   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] RepeatTerm = CNT_W'(REPEAT_TICKS - 1);

    btn_state_e       state_q;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_term;
    logic             at_term;

    // Counter is held at zero outside PRESSED/HELD and cleared on any exit or terminal hit.
    always_comb begin
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;
        cnt_term = (state_q == ST_HELD) ? RepeatTerm : HoldTerm;
        unique case (state_q)
            ST_PRESSED: begin
                if (btn_db) begin
                    cnt_clr = tick && at_term;
                    cnt_en  = tick;
                end
            end
            ST_HELD: begin
                if (btn_db) begin
                    cnt_clr = AutoRepeat && tick && at_term;
                    cnt_en  = AutoRepeat && tick;
                end
            end
            ST_LOCKOUT, ST_IDLE: ;
        endcase
    end

    tick_counter #(
        .CNT_W(CNT_W)
    ) u_tick_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .term   (cnt_term),
        .at_term(at_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOCKOUT;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            unique case (state_q)
                ST_LOCKOUT: begin
                    if (!btn_db) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (btn_db) begin
                        state_q <= ST_PRESSED;
                        press   <= 1'b1;
                        held    <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_db) begin
                        state_q       <= ST_IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (tick && at_term) begin
                        state_q    <= ST_HELD;
                        long_press <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!btn_db) begin
                        state_q       <= ST_IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (AutoRepeat && tick && at_term) begin
                        repeat_pulse <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
